// File: rtl/layer_argmax_reader.sv
// Waits until a whole fully-connected layer has finished, then snapshots the outputs.
// It scans the snapshot one element per cycle for the signed maximum and presents the winner under a valid/ack handshake.
module layer_argmax_reader #(
    parameter int INTG_WIDTH  = 16,
    parameter int FRAC_WIDTH  = 16,
    parameter int DATA_WIDTH  = INTG_WIDTH + FRAC_WIDTH,
    parameter int NUM_NEURONS = 10,
    parameter int IDX_WIDTH   = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_NEURONS-1:0]       outputs_ready,
    input  logic signed [DATA_WIDTH-1:0] values [NUM_NEURONS],
    output logic [IDX_WIDTH-1:0]         class_index,
    output logic signed [DATA_WIDTH-1:0] max_value,
    output logic                         result_valid,
    input  logic                         result_ack,
    output logic                         busy
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        DONE    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t                       state;
    logic signed [DATA_WIDTH-1:0] snapshot [NUM_NEURONS];
    logic signed [DATA_WIDTH-1:0] best_value;
    logic [IDX_WIDTH-1:0]         best_index;
    logic [IDX_WIDTH-1:0]         scan_idx;

    assign busy = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            snapshot     <= '{default: '0};
            best_value   <= '0;
            best_index   <= '0;
            scan_idx     <= '0;
            class_index  <= '0;
            max_value    <= '0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (&outputs_ready) begin
                        snapshot   <= values;
                        best_value <= values[0];
                        best_index <= '0;
                        scan_idx   <= IDX_WIDTH'(1);
                        state      <= (NUM_NEURONS > 1) ? SCAN : DONE;
                    end
                end
                SCAN: begin
                    // Strict compare so a tie keeps the earlier (lower) index.
                    if (snapshot[scan_idx] > best_value) begin
                        best_value <= snapshot[scan_idx];
                        best_index <= scan_idx;
                    end
                    scan_idx <= scan_idx + IDX_WIDTH'(1);
                    if (scan_idx == LAST_IDX) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the result; ack only counts once valid is up.
                    if (!result_valid) begin
                        result_valid <= 1'b1;
                        class_index  <= best_index;
                        max_value    <= best_value;
                    end else if (result_ack) begin
                        result_valid <= 1'b0;
                        state        <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Avoid rescanning outputs that are still flagged from the old frame.
                    if (outputs_ready == '0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_argmax_reader.sv
// Directed bench for layer_argmax_reader: a 4-neuron instance plus a 1-neuron instance.
module tb_layer_argmax_reader;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic [3:0]         ready4;
    logic signed [31:0] vals4 [4];
    logic [1:0]         idx4;
    logic signed [31:0] max4;
    logic               valid4;
    logic               ack4;
    logic               busy4;

    logic [0:0]         ready1;
    logic signed [31:0] vals1 [1];
    logic [0:0]         idx1;
    logic signed [31:0] max1;
    logic               valid1;
    logic               ack1;
    logic               busy1;

    int total = 0;
    int bad   = 0;

    layer_argmax_reader #(.NUM_NEURONS(4)) dut4 (
        .clock(clock), .reset(reset), .outputs_ready(ready4), .values(vals4),
        .class_index(idx4), .max_value(max4), .result_valid(valid4),
        .result_ack(ack4), .busy(busy4)
    );

    layer_argmax_reader #(.NUM_NEURONS(1)) dut1 (
        .clock(clock), .reset(reset), .outputs_ready(ready1), .values(vals1),
        .class_index(idx1), .max_value(max1), .result_valid(valid1),
        .result_ack(ack1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic release_frame();
        ack4 = 1'b1;
        tick(1);
        ack4 = 1'b0;
        ready4 = 4'b0000;
        tick(1);
    endtask

    initial begin
        ack4 = 1'b0;
        ack1 = 1'b0;
        ready1 = 1'b0;
        vals1[0] = 32'sh0;
        // Reset held with random inputs and all flags high.
        ready4 = 4'b1111;
        for (int i = 0; i < 4; i++) vals4[i] = $signed($urandom);
        tick(4);
        check("rst_valid", {31'b0, valid4}, 32'd0);
        check("rst_idx", {30'b0, idx4}, 32'd0);
        check("rst_max", max4, 32'd0);
        check("rst_busy", {31'b0, busy4}, 32'd0);

        ready4 = 4'b0000;
        #2 reset = 1'b1;
        tick(3);
        check("idle_after_rst", {31'b0, busy4}, 32'd0);

        // Frame A: {1,5,3,2}, result 4 edges after capture.
        vals4 = '{32'sh00010000, 32'sh00050000, 32'sh00030000, 32'sh00020000};
        ready4 = 4'b1111;
        tick(1);
        check("a_busy", {31'b0, busy4}, 32'd1);
        tick(2);
        check("a_valid_early", {31'b0, valid4}, 32'd0);
        tick(1);
        check("a_valid_e3", {31'b0, valid4}, 32'd0);
        tick(1);
        check("a_valid_e4", {31'b0, valid4}, 32'd1);
        check("a_idx", {30'b0, idx4}, 32'd1);
        check("a_max", max4, 32'h00050000);

        // Hold for 20 cycles without ack.
        tick(20);
        check("hold_valid", {31'b0, valid4}, 32'd1);
        check("hold_idx", {30'b0, idx4}, 32'd1);
        check("hold_max", max4, 32'h00050000);

        // Ack while ready still high: valid drops, stays in RELEASE.
        ack4 = 1'b1;
        tick(1);
        ack4 = 1'b0;
        check("ack_valid", {31'b0, valid4}, 32'd0);
        tick(5);
        check("rel_busy", {31'b0, busy4}, 32'd1);
        check("rel_norescan", {31'b0, valid4}, 32'd0);
        check("rel_hold_idx", {30'b0, idx4}, 32'd1);
        check("rel_hold_max", max4, 32'h00050000);
        ready4 = 4'b0000;
        tick(1);
        check("rel_to_idle", {31'b0, busy4}, 32'd0);

        // Frame B: negatives with a tie, partial ready first, inputs perturbed in SCAN.
        vals4 = '{32'shFFFD0000, 32'shFFFF0000, 32'shFFFF0000, 32'shFFF90000};
        ready4 = 4'b0111;
        tick(10);
        check("partial_busy", {31'b0, busy4}, 32'd0);
        ready4 = 4'b1111;
        tick(1);
        check("b_busy", {31'b0, busy4}, 32'd1);
        vals4 = '{32'sh7FFF0000, 32'sh7FFF0000, 32'sh7FFF0000, 32'sh7FFF0000};
        tick(4);
        check("b_valid", {31'b0, valid4}, 32'd1);
        check("b_idx", {30'b0, idx4}, 32'd1);
        check("b_max", max4, 32'hFFFF0000);
        release_frame();
        check("b_idle", {31'b0, busy4}, 32'd0);

        // Frame C: {9,2,2,2} -> index 0.
        vals4 = '{32'sh00090000, 32'sh00020000, 32'sh00020000, 32'sh00020000};
        ready4 = 4'b1111;
        tick(5);
        check("c_valid", {31'b0, valid4}, 32'd1);
        check("c_idx", {30'b0, idx4}, 32'd0);
        check("c_max", max4, 32'h00090000);
        release_frame();

        // Async reset in the middle of a scan.
        vals4 = '{32'sh00010000, 32'sh00020000, 32'sh00030000, 32'sh00040000};
        ready4 = 4'b1111;
        tick(2);
        check("mid_busy", {31'b0, busy4}, 32'd1);
        reset = 1'b0;
        #1;
        check("arst_busy", {31'b0, busy4}, 32'd0);
        check("arst_valid", {31'b0, valid4}, 32'd0);
        check("arst_idx", {30'b0, idx4}, 32'd0);
        check("arst_max", max4, 32'd0);
        ready4 = 4'b0000;
        tick(2);
        reset = 1'b1;
        tick(1);

        // Fresh frame after reset: {4,3,9,1} -> index 2.
        vals4 = '{32'sh00040000, 32'sh00030000, 32'sh00090000, 32'sh00010000};
        ready4 = 4'b1111;
        tick(5);
        check("d_valid", {31'b0, valid4}, 32'd1);
        check("d_idx", {30'b0, idx4}, 32'd2);
        check("d_max", max4, 32'h00090000);
        release_frame();

        // Single-neuron instance: result one edge after capture.
        vals1[0] = 32'sh7FFFFFFF;
        ready1 = 1'b1;
        tick(1);
        check("n1_busy", {31'b0, busy1}, 32'd1);
        check("n1_valid_e0", {31'b0, valid1}, 32'd0);
        tick(1);
        check("n1_valid_e1", {31'b0, valid1}, 32'd1);
        check("n1_idx", {31'b0, idx1}, 32'd0);
        check("n1_max", max1, 32'h7FFFFFFF);
        ack1 = 1'b1;
        tick(1);
        ack1 = 1'b0;
        ready1 = 1'b0;
        check("n1_ack", {31'b0, valid1}, 32'd0);
        tick(1);
        check("n1_idle", {31'b0, busy1}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
